// File: rtl/sevenseg_msg_sched.sv
// Display scheduler for the seven-segment controller: four prioritised message
// sources, each held for HOLD_CYCLES; station MAC shown when nothing is pending.
module sevenseg_msg_sched #(
  parameter int unsigned HOLD_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       terr_req,
  input  logic [7:0] terr_code,
  input  logic       rerr_req,
  input  logic [7:0] rerr_code,
  input  logic       dest_req,
  input  logic [7:0] dest_addr,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic [7:0] mac_addr,
  output logic [2:0] state,
  output logic [7:0] display_data,
  output logic       busy,
  output logic       ovr
);

  localparam int unsigned NSRC  = 4;
  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [2:0]  MODE_MAC = 3'b101;

  typedef enum logic {S_IDLE, S_SHOW} fsm_e;

  // Source index 0 is the highest priority (tErr), 3 the lowest (DATA).
  function automatic logic [2:0] mode_code(input logic [1:0] idx);
    case (idx)
      2'd0:    mode_code = 3'b010;
      2'd1:    mode_code = 3'b011;
      2'd2:    mode_code = 3'b001;
      default: mode_code = 3'b100;
    endcase
  endfunction

  logic [NSRC-1:0]      req_c;
  logic [NSRC-1:0][7:0] code_c;

  fsm_e                 fsm_q, fsm_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           state_q, state_d;
  logic [7:0]           data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 ovr_q, ovr_d;
  logic [NSRC-1:0]      flag_q, flag_d;
  logic [NSRC-1:0][7:0] pay_q, pay_d;

  logic                 load_c;
  logic [1:0]           sel_c;
  logic [NSRC-1:0]      clr_c;

  assign req_c  = {rx_valid, dest_req, rerr_req, terr_req};
  assign code_c = {rx_byte, dest_addr, rerr_code, terr_code};

  // Next-state: arbitration, hold countdown, output loading and pending-flag update.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    data_d  = data_q;
    busy_d  = busy_q;
    ovr_d   = 1'b0;
    flag_d  = flag_q;
    pay_d   = pay_q;
    load_c  = 1'b0;
    sel_c   = 2'd0;
    clr_c   = '0;

    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (flag_q[i]) sel_c = 2'(i);
    end

    case (fsm_q)
      S_IDLE: begin
        state_d = MODE_MAC;
        data_d  = mac_addr;
        busy_d  = 1'b0;
        if (|flag_q) load_c = 1'b1;
      end
      S_SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (|flag_q) begin
          load_c = 1'b1;
        end else begin
          fsm_d   = S_IDLE;
          state_d = MODE_MAC;
          data_d  = mac_addr;
          busy_d  = 1'b0;
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    if (load_c) begin
      fsm_d        = S_SHOW;
      state_d      = mode_code(sel_c);
      data_d       = pay_q[sel_c];
      cnt_d        = CNT_W'(HOLD_CYCLES - 1);
      busy_d       = 1'b1;
      clr_c[sel_c] = 1'b1;
    end

    // A new request beats a same-cycle clear; overwrite of a still-pending payload flags ovr.
    for (int i = 0; i < int'(NSRC); i++) begin
      if (clr_c[i]) flag_d[i] = 1'b0;
      if (req_c[i]) begin
        flag_d[i] = 1'b1;
        pay_d[i]  = code_c[i];
        if (flag_q[i] && !clr_c[i]) ovr_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      cnt_q   <= '0;
      state_q <= MODE_MAC;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      flag_q  <= '0;
      pay_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      flag_q  <= flag_d;
      pay_q   <= pay_d;
    end
  end

  assign state        = state_q;
  assign display_data = data_q;
  assign busy         = busy_q;
  assign ovr          = ovr_q;

endmodule

// File: tb/tb_sevenseg_msg_sched.sv
// Bench for sevenseg_msg_sched: timeline-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_sevenseg_msg_sched;

  localparam int HOLD = 8;

  logic       clk;
  logic       rst;
  logic       terr_req, rerr_req, dest_req, rx_valid;
  logic [7:0] terr_code, rerr_code, dest_addr, rx_byte, mac_addr;
  logic [2:0] state;
  logic [7:0] display_data;
  logic       busy, ovr;

  sevenseg_msg_sched #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst),
    .terr_req(terr_req), .terr_code(terr_code),
    .rerr_req(rerr_req), .rerr_code(rerr_code),
    .dest_req(dest_req), .dest_addr(dest_addr),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .mac_addr(mac_addr),
    .state(state), .display_data(display_data), .busy(busy), .ovr(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: absolute-time view of the display ----------------
  logic [2:0] mcode [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
  bit         pend [4];
  logic [7:0] pay  [4];
  bit         showing;
  int         hold_end;
  int         n_edge;
  bit         m_valid;
  logic [2:0] e_state;
  logic [7:0] e_data;
  logic       e_busy, e_ovr;
  logic       rq [4];
  logic [7:0] cd [4];
  int         pick;
  bit         mload, free_slot;

  always @(posedge clk) begin
    n_edge++;
    rq[0] = terr_req; rq[1] = rerr_req; rq[2] = dest_req; rq[3] = rx_valid;
    cd[0] = terr_code; cd[1] = rerr_code; cd[2] = dest_addr; cd[3] = rx_byte;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin pend[i] = 0; pay[i] = 8'h00; end
      showing = 0; hold_end = 0;
      e_state = 3'b101; e_data = 8'h00; e_busy = 0; e_ovr = 0;
      m_valid = 1;
    end else begin
      pick = -1;
      for (int i = 0; i < 4; i++) if (pend[i] && pick < 0) pick = i;
      free_slot = !showing || (n_edge >= hold_end);
      mload = (pick >= 0) && free_slot;
      e_ovr = 0;
      for (int i = 0; i < 4; i++)
        if (rq[i] && pend[i] && !(mload && pick == i)) e_ovr = 1;
      if (mload) begin
        pend[pick] = 0;
        e_state = mcode[pick]; e_data = pay[pick]; e_busy = 1;
        showing = 1; hold_end = n_edge + HOLD;
      end else if (free_slot) begin
        showing = 0;
        e_state = 3'b101; e_data = mac_addr; e_busy = 0;
      end
      for (int i = 0; i < 4; i++) if (rq[i]) begin pend[i] = 1; pay[i] = cd[i]; end
    end
  end

  // ---------------- single compare process (model + literal pins) ----------------
  int         errors = 0;
  int         checks = 0;
  bit         lit_on = 0;
  logic [2:0] l_state;
  logic [7:0] l_data;
  logic       l_busy, l_ovr;
  string      l_name;

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      checks += 4;
      if (state !== e_state) begin errors++; $display("FAIL model_state t=%0t got=%b exp=%b", $time, state, e_state); end
      if (display_data !== e_data) begin errors++; $display("FAIL model_data t=%0t got=%h exp=%h", $time, display_data, e_data); end
      if (busy !== e_busy) begin errors++; $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, e_busy); end
      if (ovr !== e_ovr) begin errors++; $display("FAIL model_ovr t=%0t got=%b exp=%b", $time, ovr, e_ovr); end
    end
    if (lit_on) begin
      checks++;
      if (state !== l_state || display_data !== l_data || busy !== l_busy || ovr !== l_ovr) begin
        errors++;
        $display("FAIL %s t=%0t got state=%b data=%h busy=%b ovr=%b exp state=%b data=%h busy=%b ovr=%b",
                 l_name, $time, state, display_data, busy, ovr, l_state, l_data, l_busy, l_ovr);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Expect these literal output values right after the next clock edge.
  task automatic exp_next(input string nm, input logic [2:0] s, input logic [7:0] d,
                          input logic b, input logic o);
    l_name = nm; l_state = s; l_data = d; l_busy = b; l_ovr = o;
    lit_on = 1;
    cyc();
    lit_on = 0;
  endtask

  task automatic clear_reqs();
    terr_req = 0; rerr_req = 0; dest_req = 0; rx_valid = 0;
  endtask

  initial begin
    rst = 1; mac_addr = 8'h3C;
    clear_reqs();
    terr_code = 8'h00; rerr_code = 8'h00; dest_addr = 8'h00; rx_byte = 8'h00;
    #2;

    // Reset, then MAC one edge after release
    exp_next("reset_vals", 3'b101, 8'h00, 0, 0);
    rst = 0;
    exp_next("mac_after_reset", 3'b101, 8'h3C, 0, 0);

    // Single DATA message, exact hold length
    rx_valid = 1; rx_byte = 8'hA5; cyc(); clear_reqs();
    exp_next("data_load", 3'b100, 8'hA5, 1, 0);
    repeat (HOLD - 1) cyc();
    exp_next("data_done", 3'b101, 8'h3C, 0, 0);

    // All four sources in one cycle, served in priority order back-to-back
    terr_req = 1; terr_code = 8'h01; rerr_req = 1; rerr_code = 8'h02;
    dest_req = 1; dest_addr = 8'h07; rx_valid = 1; rx_byte = 8'h55;
    cyc(); clear_reqs();
    exp_next("all_terr", 3'b010, 8'h01, 1, 0);
    repeat (HOLD - 1) cyc();
    exp_next("all_rerr", 3'b011, 8'h02, 1, 0);
    repeat (HOLD - 1) cyc();
    exp_next("all_dest", 3'b001, 8'h07, 1, 0);
    repeat (HOLD - 1) cyc();
    exp_next("all_data", 3'b100, 8'h55, 1, 0);
    repeat (HOLD - 1) cyc();
    exp_next("all_mac", 3'b101, 8'h3C, 0, 0);

    // Pending DEST overwritten during a DATA hold
    rx_valid = 1; rx_byte = 8'h20; cyc(); clear_reqs();
    exp_next("ovr_data_load", 3'b100, 8'h20, 1, 0);
    dest_req = 1; dest_addr = 8'h10; cyc(); clear_reqs();
    cyc();
    dest_req = 1; dest_addr = 8'h11;
    exp_next("ovr_pulse", 3'b100, 8'h20, 1, 1);
    clear_reqs();
    repeat (4) cyc();
    exp_next("ovr_dest_new", 3'b001, 8'h11, 1, 0);
    repeat (HOLD - 1) cyc();
    exp_next("ovr_mac", 3'b101, 8'h3C, 0, 0);

    // No preemption of a running hold by tErr
    rx_valid = 1; rx_byte = 8'h30; cyc(); clear_reqs();
    exp_next("nopre_load", 3'b100, 8'h30, 1, 0);
    repeat (3) cyc();
    terr_req = 1; terr_code = 8'h0E;
    exp_next("nopre_frozen", 3'b100, 8'h30, 1, 0);
    clear_reqs();
    repeat (3) cyc();
    exp_next("nopre_terr", 3'b010, 8'h0E, 1, 0);
    repeat (HOLD - 1) cyc();
    exp_next("nopre_mac", 3'b101, 8'h3C, 0, 0);

    // Reset mid-hold discards pending rErr and beats a same-cycle request
    rx_valid = 1; rx_byte = 8'h40; cyc(); clear_reqs();
    exp_next("rst_data_load", 3'b100, 8'h40, 1, 0);
    rerr_req = 1; rerr_code = 8'h66; cyc(); clear_reqs();
    cyc(); cyc();
    rst = 1; rerr_req = 1; rerr_code = 8'h77;
    exp_next("rst_mid_hold", 3'b101, 8'h00, 0, 0);
    rst = 0; clear_reqs();
    exp_next("rst_release_mac", 3'b101, 8'h3C, 0, 0);
    repeat (10) cyc();
    exp_next("rst_rerr_gone", 3'b101, 8'h3C, 0, 0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      terr_req  = ($urandom_range(0, 24) == 0);
      rerr_req  = ($urandom_range(0, 18) == 0);
      dest_req  = ($urandom_range(0, 12) == 0);
      rx_valid  = ($urandom_range(0, 5) == 0);
      terr_code = 8'($urandom); rerr_code = 8'($urandom);
      dest_addr = 8'($urandom); rx_byte   = 8'($urandom);
      if ($urandom_range(0, 99) == 0) mac_addr = 8'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 0; clear_reqs();
    repeat (5 * HOLD) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
